ins_fetch_unit: RTL and testbench
=================================

# ins_fetch_unit

Instruction fetch stage that sits directly upstream of the instruction checker. It owns the program counter and runs a request/acknowledge handshake to instruction memory. It presents each fetched word on `ins_out` with a `wait_for_next_out` qualifier, and takes the checker's `pc_choice` back to select sequential or jump addressing. It also freezes fetching when it issues a stop instruction, until the control path releases it.

## Interface
- `bus_width`, 32, instruction/data width
- `addr_width`, 16, program counter and memory address width
- `reset_vector`, 0, PC value loaded on reset
- `ack_timeout`, 15, WAIT-state cycles without `mem_ack_in` before a retry
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `pc_choice_in`  in  1  next-PC select: 1 = `pc+1`, 0 = `jump_addr_in`
- `jump_addr_in`  in  addr_width  jump target, used when `pc_choice_in`=0
- `stall_in`  in  1  downstream not ready; holds the issued instruction
- `resume_in`  in  1  leaves HALT
- `mem_ack_in`  in  1  memory data valid for the outstanding request
- `mem_data_in`  in  bus_width  instruction word from memory
- `mem_req_out`  out  1  memory request
- `mem_addr_out`  out  addr_width  request address (the current PC)
- `ins_out`  out  bus_width  issued instruction
- `wait_for_next_out`  out  1  0 only while `ins_out` holds a fresh, unconsumed instruction
- `pc_out`  out  addr_width  current PC
- `fetch_err_out`  out  1  sticky flag: at least one ack timeout has occurred

## Operation
- All outputs are registered.
- Reset values:
  - PC = `reset_vector`; `pc_out` = `reset_vector`
  - `mem_req_out` = 0; `mem_addr_out` = 0
  - `ins_out` = 0
  - `wait_for_next_out` = 1
  - `fetch_err_out` = 0
  - timeout counter = 0
  - state = FETCH
- FSM states: FETCH, WAIT, ISSUE, HALT.
- FETCH:
  - Set `mem_req_out`=1 and `mem_addr_out`=PC.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Hold the request and address stable.
  - If `mem_ack_in`=1: set `ins_out`=`mem_data_in`, `mem_req_out`=0, `wait_for_next_out`=0, and go to ISSUE.
  - Otherwise, increment the counter.
  - When the counter reaches `ack_timeout`: set `mem_req_out`=0, set `fetch_err_out`=1, and go to FETCH with the PC unchanged (retry).
- ISSUE:
  - If `stall_in`=1: stay in ISSUE; `ins_out` and `wait_for_next_out`=0 are held.
  - If `stall_in`=0: the transfer completes on this edge.
    - Set `wait_for_next_out`=1.
    - Update the PC: `pc_choice_in` ? PC+1 : `jump_addr_in`.
    - If `ins_out[bus_width-1:bus_width-6]`=6'b111111 and `ins_out[bus_width-7:bus_width-8]`=2'b11 (stop), go to HALT; otherwise go to FETCH.
- HALT:
  - No requests are issued; `wait_for_next_out`=1.
  - `resume_in`=1 moves the block to FETCH at the already-updated PC.
- PC arithmetic: modulo 2^`addr_width`; the increment from all-ones wraps to 0.
- `pc_out` always shows the current PC register.
- `mem_ack_in` is ignored outside WAIT.
- `resume_in` is ignored outside HALT.
- `pc_choice_in` and `jump_addr_in` are sampled only on the ISSUE transfer edge.

## Timing
- Best-case cycle sequence, one instruction per 3 cycles:
  - edge 1: FETCH→WAIT; request asserted
  - edge 2: ack sampled; WAIT→ISSUE; `wait_for_next_out` falls
  - edge 3: transfer; ISSUE→FETCH
- Downstream samples `ins_out` after the rising edge while `wait_for_next_out`=0. `ins_out` is stable for at least one full cycle before the transfer edge.
- Ack on the same edge that times out: the ack wins; there is no retry and no error.
- Stop instruction with `resume_in` already high at the transfer edge: enter HALT first. `resume_in` is evaluated on the next edge, so HALT lasts at least 1 cycle.
- Reset mid-operation (any state, including WAIT with a request outstanding): all outputs return to their reset values immediately.
  - A late ack after reset deasserts is ignored, because the block is in FETCH, not WAIT.
  - Fetching restarts at `reset_vector`.
- `fetch_err_out` clears only on reset.

## Test plan
- Reset, memory acks 1 cycle after request with data 0x0000_1234, `stall_in`=0, `pc_choice_in`=1:
  - `mem_addr_out` sequence 0,1,2
  - `ins_out`=0x0000_1234 with `wait_for_next_out` low for exactly 1 cycle per instruction
  - 3-cycle period
- Jump: `pc_choice_in`=0, `jump_addr_in`=0x00A0 at the transfer → next `mem_addr_out`=0x00A0. PC at 0xFFFF with `pc_choice_in`=1 → next address 0x0000.
- Hold `stall_in`=1 for 4 cycles in ISSUE:
  - `ins_out` and `wait_for_next_out`=0 are held
  - no new request is made and the PC is unchanged
  - after release: one transfer, then a fetch of PC+1
- Issue 0xFF00_0000 (stop):
  - transfer, then HALT with no requests
  - `resume_in` pulse after 5 cycles → request at PC+1
- Withhold ack for 15 WAIT cycles:
  - `mem_req_out` drops, `fetch_err_out`=1, retry at the same address
  - ack on the retry proceeds normally
  - `fetch_err_out` stays 1 until reset
- Assert `reset` while in WAIT with the request outstanding → `mem_req_out`=0, `wait_for_next_out`=1, and the next request is at `reset_vector`.

Source files
------------

// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - instruction fetch stage: PC, memory handshake, issue and halt control
module ins_fetch_unit #(
   parameter int          bus_width    = 32,
   parameter int          addr_width   = 16,
   parameter int unsigned reset_vector = 0,
   parameter int          ack_timeout  = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pc_choice_in,
   input  logic [addr_width-1:0] jump_addr_in,
   input  logic                  stall_in,
   input  logic                  resume_in,
   input  logic                  mem_ack_in,
   input  logic [bus_width-1:0]  mem_data_in,
   output logic                  mem_req_out,
   output logic [addr_width-1:0] mem_addr_out,
   output logic [bus_width-1:0]  ins_out,
   output logic                  wait_for_next_out,
   output logic [addr_width-1:0] pc_out,
   output logic                  fetch_err_out
);

   // Counter only needs to reach ack_timeout; the timeout fires on the edge it would get there.
   localparam int CW = (ack_timeout < 2) ? 1 : $clog2(ack_timeout + 1);
   localparam logic [CW-1:0]         CNT_LAST = CW'(ack_timeout - 1);
   localparam logic [addr_width-1:0] PC_RST   = addr_width'(reset_vector);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t                r_state, w_state;
   logic [addr_width-1:0] r_pc,    w_pc;
   logic                  r_req,   w_req;
   logic [addr_width-1:0] r_addr,  w_addr;
   logic [bus_width-1:0]  r_ins,   w_ins;
   logic                  r_wait,  w_wait;
   logic                  r_err,   w_err;
   logic [CW-1:0]         r_cnt,   w_cnt;
   logic                  w_stop;

   // A stop instruction carries all ones in its top eight bits (opcode 111111, function 11).
   assign w_stop = (r_ins[bus_width-1:bus_width-6] == 6'b111111) &&
                   (r_ins[bus_width-7:bus_width-8] == 2'b11);

   // Next-state and next-output logic; every register holds unless a state says otherwise.
   always_comb begin
      w_state = r_state;
      w_pc    = r_pc;
      w_req   = r_req;
      w_addr  = r_addr;
      w_ins   = r_ins;
      w_wait  = r_wait;
      w_err   = r_err;
      w_cnt   = r_cnt;
      case (r_state)
         S_FETCH: begin
            w_req   = 1'b1;
            w_addr  = r_pc;
            w_cnt   = '0;
            w_state = S_WAIT;
         end
         S_WAIT: begin
            // An ack arriving on the timeout edge takes priority: no retry, no error.
            if (mem_ack_in) begin
               w_ins   = mem_data_in;
               w_req   = 1'b0;
               w_wait  = 1'b0;
               w_state = S_ISSUE;
            end else if (r_cnt == CNT_LAST) begin
               w_cnt   = r_cnt + 1'b1;
               w_req   = 1'b0;
               w_err   = 1'b1;
               w_state = S_FETCH;
            end else begin
               w_cnt   = r_cnt + 1'b1;
            end
         end
         S_ISSUE: begin
            if (!stall_in) begin
               w_wait  = 1'b1;
               w_pc    = pc_choice_in ? (r_pc + addr_width'(1)) : jump_addr_in;
               w_state = w_stop ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            if (resume_in) begin
               w_state = S_FETCH;
            end
         end
         default: begin
            w_state = S_FETCH;
         end
      endcase
   end

   // State and output registers; reset returns everything to idle immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_pc    <= PC_RST;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_ins   <= '0;
         r_wait  <= 1'b1;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state;
         r_pc    <= w_pc;
         r_req   <= w_req;
         r_addr  <= w_addr;
         r_ins   <= w_ins;
         r_wait  <= w_wait;
         r_err   <= w_err;
         r_cnt   <= w_cnt;
      end
   end

   assign mem_req_out       = r_req;
   assign mem_addr_out      = r_addr;
   assign ins_out           = r_ins;
   assign wait_for_next_out = r_wait;
   assign pc_out            = r_pc;
   assign fetch_err_out     = r_err;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb/tb_ins_fetch_unit.sv - directed self-checking bench for ins_fetch_unit
module tb_ins_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        pc_choice_in;
   logic [15:0] jump_addr_in;
   logic        stall_in;
   logic        resume_in;
   logic        mem_ack_in;
   logic [31:0] mem_data_in;
   logic        mem_req_out;
   logic [15:0] mem_addr_out;
   logic [31:0] ins_out;
   logic        wait_for_next_out;
   logic [15:0] pc_out;
   logic        fetch_err_out;

   int n_tests = 0;
   int n_fail  = 0;

   ins_fetch_unit #(
      .bus_width   (32),
      .addr_width  (16),
      .reset_vector(0),
      .ack_timeout (15)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .pc_choice_in     (pc_choice_in),
      .jump_addr_in     (jump_addr_in),
      .stall_in         (stall_in),
      .resume_in        (resume_in),
      .mem_ack_in       (mem_ack_in),
      .mem_data_in      (mem_data_in),
      .mem_req_out      (mem_req_out),
      .mem_addr_out     (mem_addr_out),
      .ins_out          (ins_out),
      .wait_for_next_out(wait_for_next_out),
      .pc_out           (pc_out),
      .fetch_err_out    (fetch_err_out)
   );

   always #5 clock = ~clock;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset        = 1'b1;
      pc_choice_in = 1'b1;
      jump_addr_in = 16'h0000;
      stall_in     = 1'b0;
      resume_in    = 1'b0;
      mem_ack_in   = 1'b1;
      mem_data_in  = 32'h0000_1234;
      tick();
      tick();
      chk("rst_req",  64'(mem_req_out), 64'd0);
      chk("rst_addr", 64'(mem_addr_out), 64'd0);
      chk("rst_ins",  64'(ins_out), 64'd0);
      chk("rst_wait", 64'(wait_for_next_out), 64'd1);
      chk("rst_pc",   64'(pc_out), 64'd0);
      chk("rst_err",  64'(fetch_err_out), 64'd0);
      reset = 1'b0;

      // Sequential fetch: addresses 0, 1, 2 with a 3-cycle period.
      for (int a = 0; a < 3; a++) begin
         tick();
         chk("seq_req",   64'(mem_req_out), 64'd1);
         chk("seq_addr",  64'(mem_addr_out), 64'(a));
         chk("seq_wait1", 64'(wait_for_next_out), 64'd1);
         tick();
         chk("seq_req0",  64'(mem_req_out), 64'd0);
         chk("seq_ins",   64'(ins_out), 64'h0000_1234);
         chk("seq_wait0", 64'(wait_for_next_out), 64'd0);
         tick();
         chk("seq_wait2", 64'(wait_for_next_out), 64'd1);
         chk("seq_pc",    64'(pc_out), 64'(a + 1));
      end

      // Jump to 0x00A0 on the next transfer.
      tick();
      chk("jmp_addr_pre", 64'(mem_addr_out), 64'd3);
      tick();
      pc_choice_in = 1'b0;
      jump_addr_in = 16'h00A0;
      tick();
      pc_choice_in = 1'b1;
      chk("jmp_pc", 64'(pc_out), 64'h00A0);
      tick();
      chk("jmp_addr", 64'(mem_addr_out), 64'h00A0);

      // Jump to 0xFFFF, then increment wraps to 0.
      tick();
      pc_choice_in = 1'b0;
      jump_addr_in = 16'hFFFF;
      tick();
      pc_choice_in = 1'b1;
      chk("wrap_pc_ffff", 64'(pc_out), 64'hFFFF);
      tick();
      chk("wrap_addr_ffff", 64'(mem_addr_out), 64'hFFFF);
      tick();
      tick();
      chk("wrap_pc0", 64'(pc_out), 64'h0000);
      tick();
      chk("wrap_addr0", 64'(mem_addr_out), 64'h0000);
      chk("wrap_req",   64'(mem_req_out), 64'd1);

      // Stall for 4 cycles in ISSUE.
      stall_in = 1'b1;
      tick();
      chk("stl_wait_enter", 64'(wait_for_next_out), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stl_wait", 64'(wait_for_next_out), 64'd0);
         chk("stl_req",  64'(mem_req_out), 64'd0);
         chk("stl_ins",  64'(ins_out), 64'h0000_1234);
         chk("stl_pc",   64'(pc_out), 64'h0000);
      end
      stall_in = 1'b0;
      tick();
      chk("stl_rel_wait", 64'(wait_for_next_out), 64'd1);
      chk("stl_rel_pc",   64'(pc_out), 64'h0001);
      tick();
      chk("stl_next_req",  64'(mem_req_out), 64'd1);
      chk("stl_next_addr", 64'(mem_addr_out), 64'h0001);

      // Stop instruction; resume already high on the transfer edge must not skip HALT.
      mem_data_in = 32'hFF00_0000;
      tick();
      chk("stop_ins",  64'(ins_out), 64'hFF00_0000);
      chk("stop_wait", 64'(wait_for_next_out), 64'd0);
      resume_in = 1'b1;
      tick();
      resume_in = 1'b0;
      chk("stop_pc",   64'(pc_out), 64'h0002);
      chk("stop_wait1", 64'(wait_for_next_out), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("halt_req",  64'(mem_req_out), 64'd0);
         chk("halt_wait", 64'(wait_for_next_out), 64'd1);
      end
      resume_in = 1'b1;
      tick();
      resume_in = 1'b0;
      chk("resume_req0", 64'(mem_req_out), 64'd0);
      tick();
      chk("resume_req",  64'(mem_req_out), 64'd1);
      chk("resume_addr", 64'(mem_addr_out), 64'h0002);

      // Withhold ack for 15 WAIT cycles: timeout, error, retry at the same address.
      mem_data_in = 32'h0000_1234;
      mem_ack_in  = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
      end
      chk("to_req_held", 64'(mem_req_out), 64'd1);
      chk("to_err_pre",  64'(fetch_err_out), 64'd0);
      tick();
      chk("to_req_drop", 64'(mem_req_out), 64'd0);
      chk("to_err",      64'(fetch_err_out), 64'd1);
      tick();
      chk("retry_req",  64'(mem_req_out), 64'd1);
      chk("retry_addr", 64'(mem_addr_out), 64'h0002);
      mem_ack_in = 1'b1;
      tick();
      chk("retry_ins",  64'(ins_out), 64'h0000_1234);
      chk("retry_wait", 64'(wait_for_next_out), 64'd0);
      tick();
      chk("retry_pc",   64'(pc_out), 64'h0003);
      tick();
      chk("err_sticky", 64'(fetch_err_out), 64'd1);
      chk("post_addr",  64'(mem_addr_out), 64'h0003);

      // Asynchronous reset while in WAIT with the request outstanding.
      chk("pre_rst_req", 64'(mem_req_out), 64'd1);
      reset = 1'b1;
      #1;
      chk("arst_req",  64'(mem_req_out), 64'd0);
      chk("arst_wait", 64'(wait_for_next_out), 64'd1);
      chk("arst_err",  64'(fetch_err_out), 64'd0);
      chk("arst_pc",   64'(pc_out), 64'd0);
      chk("arst_addr", 64'(mem_addr_out), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("rv_req",  64'(mem_req_out), 64'd1);
      chk("rv_addr", 64'(mem_addr_out), 64'd0);
      chk("rv_wait", 64'(wait_for_next_out), 64'd1);

      // Ack on the very edge that would time out: ack wins, no error.
      mem_ack_in = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
      end
      mem_ack_in = 1'b1;
      tick();
      chk("edge_ack_wait", 64'(wait_for_next_out), 64'd0);
      chk("edge_ack_req",  64'(mem_req_out), 64'd0);
      chk("edge_ack_err",  64'(fetch_err_out), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
